// File: rtl/bp_unicore_mem_arbiter_pkg.sv
// Shared types for the unicore memory-link arbiter: message width and request source tags.
package bp_unicore_mem_arbiter_pkg;

  localparam int unsigned cce_mem_msg_width_lp = 128;

  typedef enum logic {
    e_arb_src_mem = 1'b0,
    e_arb_src_io  = 1'b1
  } bp_mem_arb_src_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based 1-read/1-write FIFO with valid/ready enqueue and valid/yumi dequeue.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp:0]  wptr_r, rptr_r;
  logic               enq, deq;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign v_o     = (wptr_r != rptr_r);
  assign ready_o = ~((wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp]) &&
                     (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]));
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rptr_r[ptr_w_lp-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + (ptr_w_lp+1)'(1);
      if (deq) rptr_r <= rptr_r + (ptr_w_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[ptr_w_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_unicore_mem_arbiter.sv
// Merges the unicore mem and io command streams onto one memory link and
// routes in-order link responses back to whichever side issued each command.
module bp_unicore_mem_arbiter
  import bp_unicore_mem_arbiter_pkg::*;
#(
  parameter  int unsigned msg_width_p       = cce_mem_msg_width_lp,
  parameter  int unsigned max_outstanding_p = 8,
  localparam int unsigned lg_outstanding_lp = $clog2(max_outstanding_p+1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic [msg_width_p-1:0]       mem_cmd_i,
  input  logic                         mem_cmd_v_i,
  output logic                         mem_cmd_ready_o,
  output logic [msg_width_p-1:0]       mem_resp_o,
  output logic                         mem_resp_v_o,
  input  logic                         mem_resp_yumi_i,

  input  logic [msg_width_p-1:0]       io_cmd_i,
  input  logic                         io_cmd_v_i,
  output logic                         io_cmd_ready_o,
  output logic [msg_width_p-1:0]       io_resp_o,
  output logic                         io_resp_v_o,
  input  logic                         io_resp_yumi_i,

  output logic [msg_width_p-1:0]       link_cmd_o,
  output logic                         link_cmd_v_o,
  input  logic                         link_cmd_ready_i,
  input  logic [msg_width_p-1:0]       link_resp_i,
  input  logic                         link_resp_v_i,
  output logic                         link_resp_yumi_o,

  output logic [lg_outstanding_lp-1:0] outstanding_o,
  output logic                         orphan_resp_o
);

  bp_mem_arb_src_e              rr_ptr_r, head_src;
  logic [msg_width_p-1:0]       link_cmd_r;
  logic                         link_cmd_v_r;
  logic [lg_outstanding_lp-1:0] outstanding_r;
  logic                         orphan_r;
  logic                         tracker_ready, tracker_v, head_tag;
  logic                         can_issue, grant_mem, grant_io;
  logic                         mem_accept, io_accept, accept, pop;

  // Readies are gated by reset so nothing is accepted while reset is held.
  assign can_issue = reset_n_i & (~link_cmd_v_r | link_cmd_ready_i) & tracker_ready;
  assign grant_mem = mem_cmd_v_i & (~io_cmd_v_i | (rr_ptr_r == e_arb_src_mem));
  assign grant_io  = io_cmd_v_i  & (~mem_cmd_v_i | (rr_ptr_r == e_arb_src_io));

  assign mem_cmd_ready_o = can_issue & grant_mem;
  assign io_cmd_ready_o  = can_issue & grant_io;
  assign mem_accept      = mem_cmd_v_i & mem_cmd_ready_o;
  assign io_accept       = io_cmd_v_i & io_cmd_ready_o;
  assign accept          = mem_accept | io_accept;

  bsg_fifo_1r1w_small #(
    .width_p (1),
    .els_p   (max_outstanding_p)
  ) tracker (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (accept),
    .ready_o   (tracker_ready),
    .data_i    (io_accept),
    .v_o       (tracker_v),
    .data_o    (head_tag),
    .yumi_i    (pop)
  );

  assign head_src         = bp_mem_arb_src_e'(head_tag);
  assign mem_resp_v_o     = link_resp_v_i & tracker_v & (head_src == e_arb_src_mem);
  assign io_resp_v_o      = link_resp_v_i & tracker_v & (head_src == e_arb_src_io);
  assign mem_resp_o       = link_resp_i;
  assign io_resp_o        = link_resp_i;
  assign pop              = (mem_resp_v_o & mem_resp_yumi_i) | (io_resp_v_o & io_resp_yumi_i);
  assign link_resp_yumi_o = pop;

  // After a grant the pointer favours the side that did not win.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r <= e_arb_src_mem;
    end else if (accept) begin
      rr_ptr_r <= mem_accept ? e_arb_src_io : e_arb_src_mem;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      link_cmd_v_r <= 1'b0;
      link_cmd_r   <= '0;
    end else if (accept) begin
      link_cmd_v_r <= 1'b1;
      link_cmd_r   <= mem_accept ? mem_cmd_i : io_cmd_i;
    end else if (link_cmd_ready_i) begin
      link_cmd_v_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      outstanding_r <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding_r <= outstanding_r + lg_outstanding_lp'(1);
        2'b01:   outstanding_r <= outstanding_r - lg_outstanding_lp'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // A response with nothing outstanding is left on the link and flagged until reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      orphan_r <= 1'b0;
    end else if (link_resp_v_i & ~tracker_v) begin
      orphan_r <= 1'b1;
    end
  end

  assign link_cmd_o    = link_cmd_r;
  assign link_cmd_v_o  = link_cmd_v_r;
  assign outstanding_o = outstanding_r;
  assign orphan_resp_o = orphan_r;

endmodule

// File: tb/tb_bp_unicore_mem_arbiter.sv
// Directed and randomized bench for bp_unicore_mem_arbiter against a queue-based reference model.
module tb_bp_unicore_mem_arbiter;

  localparam int unsigned W     = 128;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk, rst_n;
  logic [W-1:0]  mem_cmd, io_cmd, mem_resp, io_resp, link_cmd, link_resp;
  logic          mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi;
  logic          io_cmd_v, io_cmd_ready, io_resp_v, io_resp_yumi;
  logic          link_cmd_v, link_cmd_ready, link_resp_v, link_resp_yumi;
  logic [CW-1:0] outstanding;
  logic          orphan;

  bp_unicore_mem_arbiter #(.msg_width_p(W), .max_outstanding_p(DEPTH)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_i(mem_cmd), .mem_cmd_v_i(mem_cmd_v), .mem_cmd_ready_o(mem_cmd_ready),
    .mem_resp_o(mem_resp), .mem_resp_v_o(mem_resp_v), .mem_resp_yumi_i(mem_resp_yumi),
    .io_cmd_i(io_cmd), .io_cmd_v_i(io_cmd_v), .io_cmd_ready_o(io_cmd_ready),
    .io_resp_o(io_resp), .io_resp_v_o(io_resp_v), .io_resp_yumi_i(io_resp_yumi),
    .link_cmd_o(link_cmd), .link_cmd_v_o(link_cmd_v), .link_cmd_ready_i(link_cmd_ready),
    .link_resp_i(link_resp), .link_resp_v_i(link_resp_v), .link_resp_yumi_o(link_resp_yumi),
    .outstanding_o(outstanding), .orphan_resp_o(orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: commands waiting for the link, source of each issued command, favourite side.
  logic [W-1:0] pend_q[$];
  bit           src_q[$];
  bit           fav;
  bit           orphan_m;
  int           n_tests, n_fail;
  logic [W-1:0] saved;

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    src_q.delete();
    fav      = 1'b0;
    orphan_m = 1'b0;
  endtask

  // One clock: inputs already driven; checks combinational outputs, advances, checks registered outputs.
  task automatic tick();
    bit can, mw, iw, has, head, mrv, irv, ey;
    #1;
    can = (pend_q.size() == 0 || link_cmd_ready) && src_q.size() < DEPTH;
    mw  = mem_cmd_v && (!io_cmd_v || !fav);
    iw  = io_cmd_v && (!mem_cmd_v || fav);
    chk1("mem_cmd_ready", mem_cmd_ready, can && mw);
    chk1("io_cmd_ready", io_cmd_ready, can && iw);
    has  = src_q.size() != 0;
    head = has ? src_q[0] : 1'b0;
    mrv  = link_resp_v && has && !head;
    irv  = link_resp_v && has && head;
    ey   = (mrv && mem_resp_yumi) || (irv && io_resp_yumi);
    chk1("mem_resp_v", mem_resp_v, mrv);
    chk1("io_resp_v", io_resp_v, irv);
    chk1("link_resp_yumi", link_resp_yumi, ey);
    if (mrv) chkw("mem_resp_data", mem_resp, link_resp);
    if (irv) chkw("io_resp_data", io_resp, link_resp);
    if (pend_q.size() != 0 && link_cmd_ready) void'(pend_q.pop_front());
    if (can && (mw || iw)) begin
      pend_q.push_back(mw ? mem_cmd : io_cmd);
      src_q.push_back(iw);
      fav = mw;
    end
    if (ey) void'(src_q.pop_front());
    if (link_resp_v && !has) orphan_m = 1'b1;
    @(posedge clk);
    #1;
    chk1("link_cmd_v", link_cmd_v, pend_q.size() != 0);
    if (pend_q.size() != 0) chkw("link_cmd_data", link_cmd, pend_q[0]);
    chkw("outstanding", W'(outstanding), W'(src_q.size()));
    chk1("orphan", orphan, orphan_m);
  endtask

  task automatic quiet();
    mem_cmd_v = 0; io_cmd_v = 0; link_resp_v = 0;
    mem_resp_yumi = 0; io_resp_yumi = 0; link_cmd_ready = 1;
  endtask

  task automatic drain();
    quiet();
    for (int i = 0; i < 64 && (src_q.size() != 0 || pend_q.size() != 0); i++) begin
      link_resp_v = src_q.size() != 0;
      link_resp = rnd();
      mem_resp_yumi = 1; io_resp_yumi = 1;
      tick();
    end
    quiet();
    chkw("drain_outstanding", W'(outstanding), W'(0));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    model_reset();
    rst_n = 0;
    quiet();
    mem_cmd = rnd(); io_cmd = rnd(); link_resp = rnd();
    mem_cmd_v = 1; io_cmd_v = 1;
    #2;
    chk1("reset_mem_ready", mem_cmd_ready, 1'b0);
    chk1("reset_io_ready", io_cmd_ready, 1'b0);
    chk1("reset_link_cmd_v", link_cmd_v, 1'b0);
    chkw("reset_outstanding", W'(outstanding), W'(0));
    chk1("reset_orphan", orphan, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    quiet();

    // Mem only, four back-to-back commands, then four responses.
    for (int i = 0; i < 4; i++) begin
      mem_cmd_v = 1; mem_cmd = rnd();
      tick();
    end
    chkw("t1_peak_outstanding", W'(outstanding), W'(4));
    quiet();
    for (int i = 0; i < 4; i++) begin
      link_resp_v = 1; link_resp = rnd(); mem_resp_yumi = 1;
      tick();
    end
    quiet();
    chkw("t1_drained", W'(outstanding), W'(0));

    // One io command hands the favourite back to mem.
    io_cmd_v = 1; io_cmd = rnd();
    tick();
    drain();

    // Both valid continuously: mem, io, mem, io.
    for (int i = 0; i < 4; i++) begin
      mem_cmd_v = 1; io_cmd_v = 1; mem_cmd = rnd(); io_cmd = rnd();
      saved = (i % 2 == 0) ? mem_cmd : io_cmd;
      tick();
      chkw("t2_issue_order", link_cmd, saved);
    end
    drain();

    // Link stall with a command held in the output register.
    mem_cmd_v = 1; mem_cmd = rnd(); saved = mem_cmd;
    tick();
    link_cmd_ready = 0; io_cmd_v = 1; mem_cmd = rnd(); io_cmd = rnd();
    for (int i = 0; i < 5; i++) begin
      tick();
      chkw("t3_stable", link_cmd, saved);
    end
    link_cmd_ready = 1;
    tick();
    drain();

    // Fill the tracker, then a pop alongside a request must not accept that cycle.
    for (int i = 0; i < 8; i++) begin
      mem_cmd_v = 1; mem_cmd = rnd();
      tick();
    end
    chkw("t4_full", W'(outstanding), W'(DEPTH));
    io_cmd_v = 1; io_cmd = rnd();
    tick();
    io_cmd_v = 0;
    link_resp_v = 1; link_resp = rnd(); mem_resp_yumi = 1; mem_cmd = rnd();
    tick();
    chkw("t4_pop_no_accept", W'(outstanding), W'(DEPTH-1));
    link_resp_v = 0; mem_resp_yumi = 0;
    tick();
    chkw("t4_refill", W'(outstanding), W'(DEPTH));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      mem_cmd_v = 1'($urandom_range(0, 1)); mem_cmd = rnd();
      io_cmd_v  = 1'($urandom_range(0, 1)); io_cmd  = rnd();
      link_cmd_ready = ($urandom_range(0, 3) != 0);
      link_resp_v = (src_q.size() != 0) && ($urandom_range(0, 1) == 1);
      link_resp = rnd();
      mem_resp_yumi = 1'($urandom_range(0, 1));
      io_resp_yumi  = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Response with nothing outstanding.
    link_resp_v = 1; link_resp = rnd(); mem_resp_yumi = 1; io_resp_yumi = 1;
    tick();
    quiet();
    tick();
    tick();
    chk1("t5_orphan_sticky", orphan, 1'b1);

    // Reset mid-stream with three outstanding.
    for (int i = 0; i < 3; i++) begin
      io_cmd_v = 1; io_cmd = rnd();
      tick();
    end
    quiet();
    #2;
    rst_n = 0;
    #1;
    chk1("t6_link_cmd_v", link_cmd_v, 1'b0);
    chkw("t6_outstanding", W'(outstanding), W'(0));
    chk1("t6_orphan", orphan, 1'b0);
    model_reset();
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    mem_cmd_v = 1; io_cmd_v = 1; mem_cmd = rnd(); io_cmd = rnd(); saved = mem_cmd;
    tick();
    chkw("t6_mem_favoured", link_cmd, saved);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_unicore_mem_arbiter.md
Name: bp_unicore_mem_arbiter

Overview:
- Shares a single off-chip BedRock memory link between the unicore's two outgoing command streams: mem_cmd (cached DRAM traffic) and outgoing io_cmd (uncached I/O).
- Round-robin arbitrates commands into a one-entry output register.
- Records the source of every issued command in an in-order tracker.
- Steers each returning response to the requester that issued the matching command.
- Sits between bp_unicore and the chip-level link/DRAM controller.

Parameters:
- msg_width_p, cce_mem_msg_width_lp of the active bp_params_p: width of one BedRock mem message (header plus data).
- max_outstanding_p, 8: depth of the tracker; maximum commands issued but not yet answered. Power of two, at least 2.
- lg_outstanding_lp, $clog2(max_outstanding_p+1): width of the outstanding count.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- mem_cmd_i  in  msg_width_p  command from unicore mem port.
- mem_cmd_v_i  in  1  valid.
- mem_cmd_ready_o  out  1  ready (ready-valid).
- mem_resp_o  out  msg_width_p  response to unicore mem port.
- mem_resp_v_o  out  1  valid.
- mem_resp_yumi_i  in  1  consume.
- io_cmd_i  in  msg_width_p  command from unicore io port.
- io_cmd_v_i  in  1  valid.
- io_cmd_ready_o  out  1  ready.
- io_resp_o  out  msg_width_p  response to unicore io port.
- io_resp_v_o  out  1  valid.
- io_resp_yumi_i  in  1  consume.
- link_cmd_o  out  msg_width_p  merged command.
- link_cmd_v_o  out  1  valid.
- link_cmd_ready_i  in  1  ready.
- link_resp_i  in  msg_width_p  response, returned in issue order.
- link_resp_v_i  in  1  valid.
- link_resp_yumi_o  out  1  consume.
- outstanding_o  out  lg_outstanding_lp  commands in flight.
- orphan_resp_o  out  1  sticky error flag.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - Output register empty; link_cmd_v_o = 0.
  - Tracker empty; outstanding_o = 0.
  - Round-robin pointer = mem (mem wins the first tie).
  - orphan_resp_o = 0.
  - Resp valids and readies are combinational and therefore 0 while held in reset.
- A reset mid-transaction discards the in-flight command and tracker contents. There is no replay; the link partner is reset together with this block.
- Issue condition: can_issue = (~link_cmd_v_o | link_cmd_ready_i) & ~tracker_full.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the pointer's favourite wins; after each grant the pointer moves to the loser.
  - The pointer does not move on cycles with no grant.
- Readies: X_cmd_ready_o = can_issue & grant_X. Ready is asserted only to the winner; a requester that is valid but loses sees ready = 0.
- Accept (valid & ready): in the same cycle,
  - the message loads into the output register, visible on link_cmd_o at the next edge (latency 1);
  - the source tag is pushed into the tracker.
- Throughput: back-to-back accepts give one command per cycle while link_cmd_ready_i stays high. The output register holds its value stably while valid and not ready.
- Tracker full: no accept in that cycle, even if a response pops in the same cycle (no full bypass). Accept resumes the next cycle.
- Response routing:
  - head = tracker head tag.
  - mem_resp_v_o = link_resp_v_i & ~empty & head==mem; io_resp_v_o likewise for io.
  - Both resp data outputs are wired to link_resp_i.
  - link_resp_yumi_o = selected yumi_i. A pop occurs on yumi.
- Empty tracker with link_resp_v_i = 1:
  - No valid is asserted to either requester and yumi is not given; the response stays on the link.
  - orphan_resp_o sets and remains 1 until reset.
- outstanding_o: +1 on accept, -1 on pop, unchanged when both occur in the same cycle. It never exceeds max_outstanding_p.

Decomposition:
- bp_me_pkg (shared package): add the enum bp_mem_arb_src_e with e_arb_src_mem = 1'b0 and e_arb_src_io = 1'b1.
- Tracker: instantiate bsg_fifo_1r1w_small with width 1, els max_outstanding_p.
- Arbiter, output register and counter: inline in this module.

Test Plan:
- Mem only, link always ready: 4 commands A0..A3 on consecutive cycles. Expect A0..A3 on link_cmd_o at cycles 1..4 and outstanding_o peaking at 4. Four responses return to mem_resp_o only; io_resp_v_o stays 0.
- Both requesters valid continuously, link ready: expect issue order mem, io, mem, io. In-order responses R0..R3 route to mem, io, mem, io.
- Link ready held low 5 cycles with a command in the register: link_cmd_o stays stable. Both cmd readies are 0 for those 5 cycles, then accepts resume.
- Issue 8 commands with no responses: outstanding_o = 8 and both readies are 0. Then one response pop plus a pending request in the same cycle: no accept that cycle, accept on the next cycle, outstanding_o = 8 again.
- link_resp_v_i = 1 immediately after reset: link_resp_yumi_o = 0, both resp valids are 0, orphan_resp_o = 1 on the next cycle and stays 1.
- Assert reset_n_i low mid-stream at a non-edge time with 3 outstanding: link_cmd_v_o = 0 and outstanding_o = 0 immediately, and the pointer favours mem after release.
